// File: rtl/mux_nw_scan.sv
// Registered N-channel W-bit selector with manual select and auto-scan rotation; 1-cycle latency.
// No backpressure: hold freezes all state. Optional f_par output when MUX_NW_PARITY_EN is defined.
module mux_nw_scan #(
    parameter  int W     = 3,
    parameter  int N     = 4,
    parameter  int DWELL = 8,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_bus,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic              hold,
    output logic [W-1:0]      f,
    output logic [SELW-1:0]   ch,
    output logic              ch_chg,
    output logic              scan_wrap
`ifdef MUX_NW_PARITY_EN
    ,
    output logic              f_par
`endif
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    typedef enum logic {MAN, SCAN} state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic [SELW-1:0] ch_nx;
    logic [W-1:0]    f_nx;
    logic            wrap_nx;
    logic            sel_ok;

    // A mode change always takes priority over a dwell expiry on the same edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ch_nx    = ch;
        wrap_nx  = 1'b0;
        sel_ok   = ({1'b0, sel} < N_EXT);
        if (!mode) begin
            state_nx = MAN;
            cnt_nx   = '0;
            if (sel_ok)
                ch_nx = sel;
        end else if (state == MAN) begin
            state_nx = SCAN;
            cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nx  = '0;
            wrap_nx = (ch == CH_LAST);
            ch_nx   = (ch == CH_LAST) ? '0 : ch + 1'b1;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

    always_comb begin
        f_nx = '0;
        for (int k = 0; k < N; k++)
            if (ch_nx == SELW'(k))
                f_nx = in_bus[k*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MAN;
            cnt       <= '0;
            ch        <= '0;
            f         <= '0;
            ch_chg    <= 1'b0;
            scan_wrap <= 1'b0;
`ifdef MUX_NW_PARITY_EN
            f_par     <= 1'b0;
`endif
        end else if (!hold) begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ch        <= ch_nx;
            f         <= f_nx;
            ch_chg    <= (ch_nx != ch);
            scan_wrap <= wrap_nx;
`ifdef MUX_NW_PARITY_EN
            f_par     <= ^f_nx;
`endif
        end else begin
            ch_chg    <= 1'b0;
            scan_wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nw_scan.sv
// Randomised scoreboard bench for mux_nw_scan: two instances (N=4 and N=3, DWELL=3) driven in parallel.
`timescale 1ns/1ps
module tb_mux_nw_scan;

    localparam int W  = 3;
    localparam int DW = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode  = 1'b0;
    logic        hold  = 1'b0;
    logic [1:0]  sel   = '0;
    logic [11:0] bus   = '0;

    logic [2:0] f_a, f_b;
    logic [1:0] ch_a, ch_b;
    logic       chg_a, chg_b, wrap_a, wrap_b;
`ifdef MUX_NW_PARITY_EN
    logic       par_a, par_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_nw_scan #(.W(W), .N(4), .DWELL(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(bus), .mode(mode), .sel(sel), .hold(hold),
        .f(f_a), .ch(ch_a), .ch_chg(chg_a), .scan_wrap(wrap_a)
`ifdef MUX_NW_PARITY_EN
        , .f_par(par_a)
`endif
    );

    mux_nw_scan #(.W(W), .N(3), .DWELL(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(bus[8:0]), .mode(mode), .sel(sel), .hold(hold),
        .f(f_b), .ch(ch_b), .ch_chg(chg_b), .scan_wrap(wrap_b)
`ifdef MUX_NW_PARITY_EN
        , .f_par(par_b)
`endif
    );

    typedef struct {
        int f;
        int ch;
        int chg;
        int wrap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int m_ch[2];
    int m_cnt[2];
    int m_f[2];
    bit m_scan[2];

    task automatic cmp(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    // Reference: channel index modulo n, dwell counted as cycles spent on a channel.
    function automatic exp_t model_step(input int d, input int n);
        exp_t e;
        int   nx;
        e.chg  = 0;
        e.wrap = 0;
        if (hold) begin
            e.ch = m_ch[d];
            e.f  = m_f[d];
            return e;
        end
        nx = m_ch[d];
        if (!mode) begin
            m_scan[d] = 0;
            m_cnt[d]  = 0;
            if (int'(sel) < n) nx = int'(sel);
        end else if (!m_scan[d]) begin
            m_scan[d] = 1;
            m_cnt[d]  = 0;
        end else begin
            m_cnt[d]++;
            if (m_cnt[d] == DW) begin
                m_cnt[d] = 0;
                e.wrap   = (m_ch[d] == n - 1) ? 1 : 0;
                nx       = (m_ch[d] + 1) % n;
            end
        end
        e.chg   = (nx != m_ch[d]) ? 1 : 0;
        m_ch[d] = nx;
        m_f[d]  = (int'(bus) >> (nx * W)) & 7;
        e.ch    = nx;
        e.f     = m_f[d];
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_ch[d] = 0; m_cnt[d] = 0; m_f[d] = 0; m_scan[d] = 0;
            end
        end else begin
            q0.push_back(model_step(0, 4));
            q1.push_back(model_step(1, 3));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            cmp("rst_f_a", int'(f_a), 0);
            cmp("rst_ch_a", int'(ch_a), 0);
            cmp("rst_chg_a", int'(chg_a), 0);
            cmp("rst_wrap_a", int'(wrap_a), 0);
            cmp("rst_f_b", int'(f_b), 0);
            cmp("rst_ch_b", int'(ch_b), 0);
        end else begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("f_a", int'(f_a), e.f);
                cmp("ch_a", int'(ch_a), e.ch);
                cmp("ch_chg_a", int'(chg_a), e.chg);
                cmp("scan_wrap_a", int'(wrap_a), e.wrap);
`ifdef MUX_NW_PARITY_EN
                cmp("f_par_a", int'(par_a), int'(^(3'(e.f))));
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("f_b", int'(f_b), e.f);
                cmp("ch_b", int'(ch_b), e.ch);
                cmp("ch_chg_b", int'(chg_b), e.chg);
                cmp("scan_wrap_b", int'(wrap_b), e.wrap);
`ifdef MUX_NW_PARITY_EN
                cmp("f_par_b", int'(par_b), int'(^(3'(e.f))));
`endif
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        cmp("async_rst_f", int'(f_a), 0);
        cmp("async_rst_ch", int'(ch_a), 0);
        cmp("async_rst_chg", int'(chg_a), 0);
        cmp("async_rst_wrap", int'(wrap_a), 0);
    endtask

    initial begin
        bus = 12'b111_101_010_001;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Manual selection and data tracking on a fixed channel.
        sel = 2'd2;
        tick(3);
        bus[8:6] = 3'd6;
        tick(2);
        sel = 2'd3;
        tick(3);
        sel = 2'd0;
        tick(1);

        // Full scan rotation, then leave scan on the expiry edge at ch=3.
        mode = 1'b1;
        tick(12);
        mode = 1'b0;
        sel  = 2'd1;
        tick(2);

        // Freeze mid-dwell for five cycles.
        sel  = 2'd0;
        tick(1);
        mode = 1'b1;
        tick(2);
        hold = 1'b1;
        tick(5);
        hold = 1'b0;
        tick(4);

        // Asynchronous reset while sitting on channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        tick(2);
        async_reset_check();
        tick(1);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 3000; i++) begin
            bus = 12'($urandom);
            sel = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            hold = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) async_reset_check();
            else rst_n = 1'b1;
            tick(1);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
